bforge_apb_requester: RTL and testbench

//  APB4 requester (initiator). Converts a valid/ready command stream into one APB transfer at a time.

---
 rtl/bforge_apb_pkg.sv | 32 +++
 rtl/bforge_apb_wait_timer.sv | 38 +++
 rtl/bforge_apb_requester.sv | 134 +++++++++++++
 tb/tb_bforge_apb_requester.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bforge_apb_pkg.sv
// Shared types for the bforge APB requester: FSM state encoding plus
// command/response records sized by the BFORGE_APB_*_WIDTH macros.
`ifndef BFORGE_APB_ADDR_WIDTH
`define BFORGE_APB_ADDR_WIDTH 32
`endif
`ifndef BFORGE_APB_DATA_WIDTH
`define BFORGE_APB_DATA_WIDTH 32
`endif

package bforge_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_req_state_e;

  typedef struct packed {
    logic [`BFORGE_APB_ADDR_WIDTH-1:0]   addr;
    logic                                write;
    logic [`BFORGE_APB_DATA_WIDTH-1:0]   wdata;
    logic [`BFORGE_APB_DATA_WIDTH/8-1:0] strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [`BFORGE_APB_DATA_WIDTH-1:0] rdata;
    logic                              slverr;
    logic                              timeout;
  } apb_rsp_t;

endpackage

// File: rtl/bforge_apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; expired flags the last permitted
// wait cycle. Never expires when TIMEOUT_CYCLES is 0.
module bforge_apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/bforge_apb_requester.sv
// APB4 requester: one valid/ready command becomes one APB transfer, whose
// completion (or timeout abort) is returned on a valid/ready response stream.
module bforge_apb_requester
  import bforge_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_req_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic                  timeout_q, timeout_d;
  logic                  accept, wait_en, expired;

  assign cmd_ready = (state_q == IDLE) && !preset;
  assign accept    = cmd_valid && cmd_ready;
  assign wait_en   = (state_q == ACCESS) && !pready;

  bforge_apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (pclk),
    .rst    (preset),
    .clear  (accept),
    .enable (wait_en),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Read data/strobes are zeroed at capture so the bus never shows them.
          addr_d  = cmd_addr;
          write_d = cmd_write;
          wdata_d = cmd_write ? cmd_wdata : '0;
          strb_d  = cmd_write ? cmd_strb : '0;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready takes priority over a timeout firing in the same cycle.
        if (pready) begin
          rdata_d   = write_q ? '0 : prdata;
          slverr_d  = pslverr;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (expired) begin
          rdata_d   = '0;
          slverr_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      timeout_q <= timeout_d;
    end
  end

  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign paddr       = addr_q;
  assign pwrite      = write_q;
  assign pwdata      = wdata_q;
  assign pstrb       = strb_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_bforge_apb_requester.sv
// Self-checking bench for bforge_apb_requester: directed vector table,
// randomized transfers against a transfer-level model, and mid-transfer reset.
module tb_bforge_apb_requester;

  localparam int unsigned T = 8;

  logic        pclk, preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;

  bforge_apb_requester #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // One transfer: stimulus, completer behaviour and expected response.
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int unsigned waits;   // ACCESS cycles with pready=0 before pready=1
    logic [31:0] prdata;
    logic        slverr;
    int unsigned delay;   // cycles rsp_ready is held low once rsp_valid rises
    logic [31:0] e_rdata;
    logic        e_slverr;
    logic        e_timeout;
    int unsigned e_rc;    // cycle (accept = 0) in which rsp_valid rises
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level reference: a completer that stalls T or more cycles is aborted
  // after exactly T ACCESS cycles; otherwise the ACCESS phase lasts waits+1 cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.waits >= T) begin
      r.e_timeout = 1'b1;
      r.e_slverr  = 1'b1;
      r.e_rdata   = '0;
      r.e_rc      = 2 + T;
    end else begin
      r.e_timeout = 1'b0;
      r.e_slverr  = v.slverr;
      r.e_rdata   = v.write ? 32'h0 : v.prdata;
      r.e_rc      = 3 + v.waits;
    end
    return r;
  endfunction

  task automatic run_xfer(input vec_t v);
    int unsigned acc = v.e_rc - 2;
    int unsigned h   = v.e_rc + v.delay;
    logic [31:0] exp_wd = v.write ? v.wdata : 32'h0;
    logic [3:0]  exp_st = v.write ? v.strb : 4'h0;
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_write = v.write;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    for (int unsigned cyc = 0; cyc <= h; cyc++) begin
      if (cyc > 0) begin
        @(posedge pclk);
        #1;
        // junk command held valid while busy must never be taken
        cmd_valid = 1'b1;
        cmd_addr  = $urandom;
        cmd_write = 1'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
      end
      check("handshake", 64'({psel, penable, cmd_ready, rsp_valid}),
            64'({(cyc >= 1 && cyc <= 1 + acc), (cyc >= 2 && cyc <= 1 + acc),
                 (cyc == 0), (cyc >= v.e_rc)}));
      if (cyc >= 1 && cyc <= 1 + acc) begin
        check("paddr", 64'(paddr), 64'(v.addr));
        check("pctl", 64'({pwrite, pstrb, pwdata}), 64'({v.write, exp_st, exp_wd}));
      end
      if (cyc >= v.e_rc)
        check("rsp", 64'({rsp_timeout, rsp_slverr, rsp_rdata}),
              64'({v.e_timeout, v.e_slverr, v.e_rdata}));
      if (cyc >= 2 && cyc <= 1 + acc && (cyc - 1) == v.waits + 1) begin
        pready  = 1'b1;
        prdata  = v.prdata;
        pslverr = v.slverr;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = ~v.slverr;
      end
      rsp_ready = (cyc == h) || (cyc < v.e_rc && $urandom_range(1, 0) == 1);
    end
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    check("post_rsp", 64'({psel, penable, cmd_ready, rsp_valid}), 64'(4'b0010));
  endtask

  initial begin
    vec_t v;
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    #1;
    check("reset_ctl", 64'({psel, penable, cmd_ready, rsp_valid, pwrite, rsp_slverr, rsp_timeout}), 64'(0));
    check("reset_data", 64'({paddr, pwdata}), 64'(0));
    check("reset_rsp", 64'({pstrb, rsp_rdata}), 64'(0));
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    #1;
    check("reset_release", 64'(cmd_ready), 64'(1));

    //               wr    addr        wdata         strb  waits prdata        err   dly e_rdata       e_err e_to  e_rc
    tbl.push_back('{1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 0,  32'h1111_2222, 1'b0, 0, 32'h0,         1'b0, 1'b0, 3});
    tbl.push_back('{1'b0, 32'h20, 32'h5555_AAAA, 4'hF, 3,  32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 6});
    tbl.push_back('{1'b1, 32'h30, 32'h0123_4567, 4'h3, 2,  32'h0,         1'b1, 1, 32'h0,         1'b1, 1'b0, 5});
    tbl.push_back('{1'b0, 32'h34, 32'h0,         4'h0, 2,  32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0, 1'b0, 5});
    tbl.push_back('{1'b0, 32'h40, 32'h0,         4'hF, 20, 32'hFFFF_FFFF, 1'b0, 0, 32'h0,         1'b1, 1'b1, 10});
    tbl.push_back('{1'b0, 32'h44, 32'h0,         4'h0, 7,  32'hCAFE_0001, 1'b0, 0, 32'hCAFE_0001, 1'b0, 1'b0, 10});
    tbl.push_back('{1'b1, 32'h48, 32'h7,         4'h1, 8,  32'h0,         1'b0, 2, 32'h0,         1'b1, 1'b1, 10});
    tbl.push_back('{1'b1, 32'h50, 32'hFEED_F00D, 4'hC, 1,  32'h0,         1'b1, 5, 32'h0,         1'b1, 1'b0, 4});
    foreach (tbl[i]) run_xfer(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.write  = 1'($urandom);
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.strb   = 4'($urandom);
      v.waits  = $urandom_range(11, 0);
      v.prdata = $urandom;
      v.slverr = 1'($urandom);
      v.delay  = $urandom_range(3, 0);
      run_xfer(model(v));
    end

    // Reset while the completer is stalling in ACCESS.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h60;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    pready    = 1'b0;
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    @(posedge pclk);
    #1;
    @(posedge pclk);
    #1;
    check("mid_busy", 64'({psel, penable}), 64'(2'b11));
    #2;
    preset    = 1'b1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    #1;
    check("rst_async", 64'({psel, penable, cmd_ready, rsp_valid}), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    @(posedge pclk);
    #1;
    check("rst_hold", 64'({psel, penable, cmd_ready, rsp_valid}), 64'(0));
    cmd_valid = 1'b0;
    preset    = 1'b0;
    #1;
    check("rst_release", 64'({psel, penable, cmd_ready, rsp_valid}), 64'(4'b0010));
    repeat (3) begin
      @(posedge pclk);
      #1;
      check("rst_after", 64'({psel, penable, cmd_ready, rsp_valid}), 64'(4'b0010));
    end
    rsp_ready = 1'b0;
    run_xfer(tbl[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
